// File: rtl/mafia_game_ctrl.sv
// Turn controller for a two-faction elimination game: one button press commits one
// night/day action, with alive counts, win detection, round count and display state.
module mafia_game_ctrl #(
    parameter int N_MAFIA   = 2,
    parameter int N_CITIZEN = 4,
    parameter int INV_HOLD  = 4,
    parameter int ROUND_W   = 4,
    localparam int CNT_W    = $clog2(N_CITIZEN + 1)
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 Enable,
    input  logic [1:0]           Switch_Input,
    output logic [CNT_W-1:0]     mafia_alive,
    output logic [CNT_W-1:0]     citizen_alive,
    output logic [N_MAFIA-1:0]   LED_MAFIA,
    output logic [N_CITIZEN-1:0] LED_CITIZEN,
    output logic                 LED_WHITE,
    output logic                 game_over,
    output logic                 winner,
    output logic                 invalid_flag,
    output logic [ROUND_W-1:0]   round_cnt,
    output logic [1:0]           disp_mode
);

    localparam int INV_W = $clog2(INV_HOLD + 1);

    localparam logic [1:0] NIGHT = 2'd0;
    localparam logic [1:0] DAY   = 2'd1;
    localparam logic [1:0] OVER  = 2'd2;

    localparam logic [1:0] CODE_CITIZEN = 2'b00;
    localparam logic [1:0] CODE_MAFIA   = 2'b01;
    localparam logic [1:0] CODE_SKIP    = 2'b10;

    localparam logic [1:0] DISP_SCORE   = 2'b00;
    localparam logic [1:0] DISP_WINNER  = 2'b01;
    localparam logic [1:0] DISP_INVALID = 2'b10;

    logic                 enable_d_q;
    logic [1:0]           state_q,        state_d;
    logic [CNT_W-1:0]     mafia_q,        mafia_d;
    logic [CNT_W-1:0]     citizen_q,      citizen_d;
    logic [ROUND_W-1:0]   round_q,        round_d;
    logic [INV_W-1:0]     inv_cnt_q,      inv_cnt_d;
    logic                 winner_q,       winner_d;
    logic                 invalid_flag_q, invalid_flag_d;
    logic                 led_white_q,    led_white_d;
    logic                 game_over_q,    game_over_d;
    logic [1:0]           disp_mode_q,    disp_mode_d;
    logic [N_MAFIA-1:0]   led_mafia_q,    led_mafia_d;
    logic [N_CITIZEN-1:0] led_citizen_q,  led_citizen_d;

    logic strobe;
    logic valid_act;
    logic invalid_act;

    always_comb begin
        strobe      = Enable & ~enable_d_q;
        valid_act   = 1'b0;
        invalid_act = 1'b0;
        state_d     = state_q;
        mafia_d     = mafia_q;
        citizen_d   = citizen_q;
        round_d     = round_q;
        winner_d    = winner_q;
        inv_cnt_d   = (inv_cnt_q != '0) ? inv_cnt_q - INV_W'(1) : '0;

        if (strobe && state_q != OVER) begin
            case (Switch_Input)
                CODE_CITIZEN: begin
                    if (citizen_q != '0) begin
                        valid_act = 1'b1;
                        citizen_d = citizen_q - CNT_W'(1);
                    end else begin
                        invalid_act = 1'b1;
                    end
                end
                CODE_MAFIA: begin
                    if (state_q == DAY && mafia_q != '0) begin
                        valid_act = 1'b1;
                        mafia_d   = mafia_q - CNT_W'(1);
                    end else begin
                        invalid_act = 1'b1;
                    end
                end
                CODE_SKIP: valid_act   = 1'b1;
                default:   invalid_act = 1'b1;
            endcase
        end

        if (invalid_act) begin
            inv_cnt_d = INV_W'(INV_HOLD);
        end

        // The win check looks at the post-action counts; a day action always closes a round.
        if (valid_act) begin
            inv_cnt_d = '0;
            if (state_q == DAY && round_q != '1) begin
                round_d = round_q + ROUND_W'(1);
            end
            if (mafia_d == '0) begin
                state_d  = OVER;
                winner_d = 1'b1;
            end else if (mafia_d >= citizen_d) begin
                state_d  = OVER;
                winner_d = 1'b0;
            end else begin
                state_d = (state_q == DAY) ? NIGHT : DAY;
            end
        end

        invalid_flag_d = (inv_cnt_d != '0);
        led_white_d    = (state_d == DAY);
        game_over_d    = (state_d == OVER);
        if (invalid_flag_d) begin
            disp_mode_d = DISP_INVALID;
        end else if (state_d == OVER) begin
            disp_mode_d = DISP_WINNER;
        end else begin
            disp_mode_d = DISP_SCORE;
        end

        led_mafia_d = '0;
        for (int i = 0; i < N_MAFIA; i++) begin
            led_mafia_d[i] = (CNT_W'(i) < mafia_d);
        end
        led_citizen_d = '0;
        for (int i = 0; i < N_CITIZEN; i++) begin
            led_citizen_d[i] = (CNT_W'(i) < citizen_d);
        end
    end

    // Enable_d starts high so a button held through reset cannot fire an action.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            enable_d_q     <= 1'b1;
            state_q        <= NIGHT;
            mafia_q        <= CNT_W'(N_MAFIA);
            citizen_q      <= CNT_W'(N_CITIZEN);
            round_q        <= '0;
            inv_cnt_q      <= '0;
            winner_q       <= 1'b0;
            invalid_flag_q <= 1'b0;
            led_white_q    <= 1'b0;
            game_over_q    <= 1'b0;
            disp_mode_q    <= DISP_SCORE;
            led_mafia_q    <= '1;
            led_citizen_q  <= '1;
        end else begin
            enable_d_q     <= Enable;
            state_q        <= state_d;
            mafia_q        <= mafia_d;
            citizen_q      <= citizen_d;
            round_q        <= round_d;
            inv_cnt_q      <= inv_cnt_d;
            winner_q       <= winner_d;
            invalid_flag_q <= invalid_flag_d;
            led_white_q    <= led_white_d;
            game_over_q    <= game_over_d;
            disp_mode_q    <= disp_mode_d;
            led_mafia_q    <= led_mafia_d;
            led_citizen_q  <= led_citizen_d;
        end
    end

    assign mafia_alive   = mafia_q;
    assign citizen_alive = citizen_q;
    assign LED_MAFIA     = led_mafia_q;
    assign LED_CITIZEN   = led_citizen_q;
    assign LED_WHITE     = led_white_q;
    assign game_over     = game_over_q;
    assign winner        = winner_q;
    assign invalid_flag  = invalid_flag_q;
    assign round_cnt     = round_q;
    assign disp_mode     = disp_mode_q;

endmodule

// File: doc/mafia_game_ctrl.md
MAFIA_GAME_CTRL -- requirements
Module: mafia_game_ctrl

Interface
REQ-001 Parameter N_MAFIA, default 2, initial mafia count; SHALL be at least 1.
REQ-002 Parameter N_CITIZEN, default 4, initial citizen count; SHALL be greater than N_MAFIA.
REQ-003 Parameter INV_HOLD, default 4, cycles the invalid flag is held (at least 1).
REQ-004 Parameter ROUND_W, default 4, width of the round counter.
REQ-005 Derived width CNT_W SHALL be ceil(log2(N_CITIZEN+1)), used for both alive counts.
REQ-006 CLK  in  1  single clock; all state updates on its rising edge.
REQ-007 RESET  in  1  synchronous, active-high reset.
REQ-008 Enable  in  1  confirm button, level input; its rising edge commits one action.
REQ-009 Switch_Input  in  2  action code: 00 kill/vote out a citizen; 01 vote out a mafia; 10 skip; 11 invalid.
REQ-010 mafia_alive  out  CNT_W  current mafia count.
REQ-011 citizen_alive  out  CNT_W  current citizen count.
REQ-012 LED_MAFIA  out  N_MAFIA  thermometer of live mafia (bit i=1 iff i < mafia_alive).
REQ-013 LED_CITIZEN  out  N_CITIZEN  thermometer of live citizens.
REQ-014 LED_WHITE  out  1  1 = day, 0 = night or game over.
REQ-015 game_over  out  1  game terminated.
REQ-016 winner  out  1  valid only when game_over: 1 = citizens, 0 = mafia.
REQ-017 invalid_flag  out  1  rejected-action indicator.
REQ-018 round_cnt  out  ROUND_W  completed night+day rounds, saturating.
REQ-019 disp_mode  out  2  display selector: 00 score, 01 winner, 10 invalid.

Function
REQ-020 The block SHALL register Enable into Enable_d each cycle; action strobe = Enable & ~Enable_d.
REQ-021 The FSM SHALL have states NIGHT, DAY and OVER; all outputs SHALL be registered and reflect a strobe one cycle after it.
REQ-022 In NIGHT, code 00 SHALL decrement citizen_alive, code 10 SHALL leave counts unchanged; either SHALL move the FSM to DAY.
REQ-023 In DAY, code 00 SHALL decrement citizen_alive, code 01 SHALL decrement mafia_alive, code 10 SHALL leave counts unchanged; any of these SHALL move the FSM to NIGHT and increment round_cnt, saturating at all-ones.
REQ-024 An action SHALL be invalid if the code is 11, or the code is 01 in NIGHT, or it targets a group whose count is 0; an invalid action SHALL change no count, state or round_cnt.
REQ-025 After each valid action, the win check SHALL use the new counts: mafia_alive==0 -> OVER with winner=1; otherwise mafia_alive >= citizen_alive -> OVER with winner=0; otherwise follow REQ-022/023.
REQ-026 In OVER, strobes SHALL be ignored, including invalid codes; only RESET SHALL leave OVER.
REQ-027 An invalid action SHALL set invalid_flag for exactly INV_HOLD cycles; a new invalid action SHALL restart the count; a valid action SHALL clear it on the next cycle.
REQ-028 disp_mode SHALL be 10 while invalid_flag=1, else 01 in OVER, else 00.
REQ-029 LED_WHITE SHALL be 1 only in DAY.
REQ-030 Counts SHALL never underflow or exceed their initial values.

Reset
REQ-031 While RESET=1 at a clock edge, the block SHALL load: state NIGHT, mafia_alive=N_MAFIA, citizen_alive=N_CITIZEN, all LED_MAFIA/LED_CITIZEN bits 1, LED_WHITE=0, game_over=0, winner=0, invalid_flag=0, round_cnt=0, disp_mode=00, Enable_d=1.
REQ-032 RESET SHALL override a coincident strobe, including one arriving mid-game or in OVER.
REQ-033 Because Enable_d resets to 1, an Enable held high through reset SHALL NOT produce a strobe until it is released and pressed again.

Verification (defaults 2/4/4/4)
REQ-034 Reset, then night 00 -> citizen_alive=3, LED_WHITE=1 one cycle after the strobe, disp_mode=00.
REQ-035 Night 01 -> invalid_flag=1 and disp_mode=10 for 4 cycles, counts unchanged, state NIGHT; then valid 10 -> DAY.
REQ-036 Sequence night 00, day 00 -> counts 2/2 -> game_over=1, winner=0, LED_CITIZEN=0011, disp_mode=01.
REQ-037 Sequence night 10, day 01, night 10, day 01 -> mafia_alive=0, winner=1, round_cnt=2; a further strobe with code 11 -> no invalid_flag.
REQ-038 Enable held high across RESET deassertion -> no action; release and press -> exactly one action; RESET on the same cycle as a strobe -> reset values only.
